hazard_bypass_ctrl: RTL and testbench
=====================================

# hazard_bypass_ctrl

Pipeline hazard and bypass controller that produces the per-operand forwarding enables (`EX_D_bp`, `MEM_D_bp`, `WB_D_bp`) and the load-use stall consumed by the decode-stage register file. It tracks the destination tag of every in-flight instruction through EX, MEM and WB in a small shift pipeline. It compares those tags against the decode-stage source registers and drives decode stall and bubble insertion. It sits beside the register file in decode and is the only producer of its bypass controls.

## Interface
Parameters:
- `ADDR_SIZE`, 5, register-index width
- `CNT_W`, 32, stall-counter width

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `D_valid`  in  1  decode slot holds a real instruction
- `D_ra`, `D_rb`  in  ADDR_SIZE each  decode source registers
- `D_use_ra`, `D_use_rb`  in  1 each  the instruction actually reads that source
- `D_we`  in  1  the instruction writes a register
- `D_rd`  in  ADDR_SIZE  destination register
- `D_ld`  in  1  the instruction is a load
- `flush`  in  1  taken branch: kill the decode instruction
- `EX_D_bp`, `MEM_D_bp`, `WB_D_bp`  out  2 each  forwarding enables, bit 1 = ra, bit 0 = rb
- `D_stall`  out  1  hold fetch/decode this cycle
- `stall_cnt`  out  CNT_W  saturating count of load-use stall cycles

## Operation
- **Tag pipeline.** Three stage registers: EX, MEM and WB. Each holds {v, we, rd, ld}.
- **Tag advance.** Every rising edge: WB←MEM, MEM←EX. EX←{D_valid & ~D_stall & ~flush, D_we, D_rd, D_ld}. A killed or stalled slot enters EX with v=0 as a bubble.
- **Tag hit.** Stage S hits operand X when all of the following hold: S.v & S.we, S.rd == D_rX, D_rX != 0, D_use_rX and D_valid.
- **Forwarding selection.** Per operand bit, only the youngest hit stage has its bit set: EX over MEM over WB. At most one of the three bits at position X is 1. Register 0 is never forwarded.
- **Load-use stall.** An EX hit whose EX.ld=1 is a load-use. It drives D_stall=1 and clears that operand's EX bit. MEM and WB bits are still computed, but D_stall tells the consumer to discard the value.
- **Flush priority.** `flush` overrides the stall. When `flush`=1, D_stall=0 and a bubble enters EX.
- **Stall counter.** `stall_cnt` increments on each edge where D_stall=1. It saturates at all-ones.
- **Combinational outputs.** The bypass outputs and D_stall are combinational from the current tags and decode inputs. The tags are registered.

## Timing
- **Reset.** While `rst_n`=0, all tag valids are cleared and `stall_cnt`=0 immediately, so all bypass outputs and D_stall read 0. The first edge after release captures normally.
- **Mid-operation reset.** Discards all tracked tags. No residual forwarding after release.
- **Latency to EX forwarding.** A producer in decode at cycle t drives an EX hit at t+1.
- **Later forwarding stages.** It drives a MEM hit at t+2 and a WB hit at t+3. At t+4 there is no hit; the register file holds the written value.
- **Load-use stall length.** Exactly one cycle. At t+1, D_stall=1 and a bubble is inserted. At t+2 the load is in MEM, so MEM_D_bp is set and D_stall=0.
- **Simultaneous writers.** When EX, MEM and WB all write the same rd, only the EX bit is set (or a stall occurs if EX is a load).
- **Both operands.** When both operands hit different stages, each bit is resolved independently.
- **Back-to-back.** Back-to-back stalls are possible: the counter increments each cycle.

## Structure
- **Shared package.** Holds the stage-tag struct {v, we, rd, ld}, the bypass bit positions (RA_BIT=1, RB_BIT=0) and ADDR_SIZE.
- **Sub-module `bp_match`.** Compares one stage tag against one source register and returns a hit bit. It is instantiated 6 times: 3 stages × 2 operands.
- **Top level.** Owns the tag shift registers, priority selection, stall logic and counter.

## Test plan
- **Reset.** Drive rst_n=0 mid-stream with tags valid → all bypass outputs 0, D_stall=0, stall_cnt=0 asynchronously; no forwarding after release.
- **ALU chain.** Decode sequence: add r5; then use ra=5; then use rb=5 two cycles later.
  - The second instruction sees EX_D_bp=2'b10.
  - The third sees MEM_D_bp=2'b01.
  - A use at t+3 gives WB_D_bp=2'b10.
  - A use at t+4 gives all zero.
- **Load-use.** Decode sequence: load r7, then use ra=7.
  - One cycle of D_stall=1 with EX_D_bp=0.
  - Next cycle D_stall=0 and MEM_D_bp=2'b10.
  - stall_cnt=1.
- **Priority.** Writers to r3 sit in EX, MEM and WB, and the decode instruction uses ra=rb=3 → EX_D_bp=2'b11, MEM_D_bp=0, WB_D_bp=0.
- **r0 and unused operands.** Writer to r0 followed by a use of r0 → no bypass. Writer to r4 with D_use_rb=0 and D_rb=4 → rb bit 0.
- **Flush during stall.** Load r2, then use r2 with flush=1 → D_stall=0, EX tag v=0 next cycle, stall_cnt unchanged.

Source files
------------

// File: rtl/hazard_bypass_ctrl_pkg.sv
// Shared types for the decode-stage hazard/bypass controller: the per-stage
// destination tag and the operand bit positions of the bypass vectors.
package hazard_bypass_ctrl_pkg;

  localparam int ADDR_SIZE = 5;

  localparam int RA_BIT = 1;
  localparam int RB_BIT = 0;

  localparam int N_STAGES = 3;
  localparam int ST_EX    = 0;
  localparam int ST_MEM   = 1;
  localparam int ST_WB    = 2;

  typedef struct packed {
    logic                 v;
    logic                 we;
    logic [ADDR_SIZE-1:0] rd;
    logic                 ld;
  } stage_tag_t;

endpackage

// File: rtl/bp_match.sv
// Compares one in-flight stage tag with one decode source register.
// A hit means the stage holds a newer value of that register than the regfile.
module bp_match
  import hazard_bypass_ctrl_pkg::*;
(
  input  stage_tag_t           tag,
  input  logic [ADDR_SIZE-1:0] src,
  input  logic                 use_src,
  input  logic                 d_valid,
  output logic                 hit
);

  logic unused_tag_ld;
  assign unused_tag_ld = tag.ld;

  // r0 is hardwired zero, so a write to it never produces forwardable data
  assign hit = tag.v && tag.we && (tag.rd == src) && (src != '0) &&
               use_src && d_valid;

endmodule

// File: rtl/hazard_bypass_ctrl.sv
// Decode-stage hazard controller: shifts destination tags through EX/MEM/WB,
// picks the youngest forwarding source per operand and detects load-use stalls.
module hazard_bypass_ctrl
  import hazard_bypass_ctrl_pkg::*;
#(
  parameter int ADDR_SIZE = hazard_bypass_ctrl_pkg::ADDR_SIZE,
  parameter int CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 D_valid,
  input  logic [ADDR_SIZE-1:0] D_ra,
  input  logic [ADDR_SIZE-1:0] D_rb,
  input  logic                 D_use_ra,
  input  logic                 D_use_rb,
  input  logic                 D_we,
  input  logic [ADDR_SIZE-1:0] D_rd,
  input  logic                 D_ld,
  input  logic                 flush,
  output logic [1:0]           EX_D_bp,
  output logic [1:0]           MEM_D_bp,
  output logic [1:0]           WB_D_bp,
  output logic                 D_stall,
  output logic [CNT_W-1:0]     stall_cnt
);

  stage_tag_t          tags [N_STAGES];
  logic [N_STAGES-1:0] hit_ra;
  logic [N_STAGES-1:0] hit_rb;
  logic                lu_ra;
  logic                lu_rb;

  for (genvar s = 0; s < N_STAGES; s++) begin : g_stage
    bp_match u_match_ra (
      .tag     (tags[s]),
      .src     (D_ra),
      .use_src (D_use_ra),
      .d_valid (D_valid),
      .hit     (hit_ra[s])
    );
    bp_match u_match_rb (
      .tag     (tags[s]),
      .src     (D_rb),
      .use_src (D_use_rb),
      .d_valid (D_valid),
      .hit     (hit_rb[s])
    );
  end

  logic unused_wb_ld;
  assign unused_wb_ld = tags[ST_WB].ld;

  // A load in EX has no data yet: its hit becomes a stall instead of a bypass,
  // and it still masks the older stages because their value is stale.
  always_comb begin
    lu_ra    = hit_ra[ST_EX] & tags[ST_EX].ld;
    lu_rb    = hit_rb[ST_EX] & tags[ST_EX].ld;
    D_stall  = (lu_ra | lu_rb) & ~flush;

    EX_D_bp  = '0;
    MEM_D_bp = '0;
    WB_D_bp  = '0;

    EX_D_bp[RA_BIT]  = hit_ra[ST_EX] & ~tags[ST_EX].ld;
    EX_D_bp[RB_BIT]  = hit_rb[ST_EX] & ~tags[ST_EX].ld;
    MEM_D_bp[RA_BIT] = hit_ra[ST_MEM] & ~hit_ra[ST_EX];
    MEM_D_bp[RB_BIT] = hit_rb[ST_MEM] & ~hit_rb[ST_EX];
    WB_D_bp[RA_BIT]  = hit_ra[ST_WB] & ~hit_ra[ST_EX] & ~hit_ra[ST_MEM];
    WB_D_bp[RB_BIT]  = hit_rb[ST_WB] & ~hit_rb[ST_EX] & ~hit_rb[ST_MEM];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < N_STAGES; s++) begin
        tags[s] <= '0;
      end
    end else begin
      tags[ST_WB]     <= tags[ST_MEM];
      tags[ST_MEM]    <= tags[ST_EX];
      tags[ST_EX].v   <= D_valid & ~D_stall & ~flush;
      tags[ST_EX].we  <= D_we;
      tags[ST_EX].rd  <= D_rd;
      tags[ST_EX].ld  <= D_ld;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (D_stall && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_bypass_ctrl.sv
// Directed bench for hazard_bypass_ctrl: each step drives one decode slot just
// after a rising edge and checks the combinational outputs before the next edge.
module tb_hazard_bypass_ctrl;

  localparam int AW = 5;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          D_valid;
  logic [AW-1:0] D_ra;
  logic [AW-1:0] D_rb;
  logic          D_use_ra;
  logic          D_use_rb;
  logic          D_we;
  logic [AW-1:0] D_rd;
  logic          D_ld;
  logic          flush;
  logic [1:0]    EX_D_bp;
  logic [1:0]    MEM_D_bp;
  logic [1:0]    WB_D_bp;
  logic          D_stall;
  logic [CW-1:0] stall_cnt;

  int errors = 0;
  int checks = 0;

  hazard_bypass_ctrl #(.ADDR_SIZE(AW), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .D_valid   (D_valid),
    .D_ra      (D_ra),
    .D_rb      (D_rb),
    .D_use_ra  (D_use_ra),
    .D_use_rb  (D_use_rb),
    .D_we      (D_we),
    .D_rd      (D_rd),
    .D_ld      (D_ld),
    .flush     (flush),
    .EX_D_bp   (EX_D_bp),
    .MEM_D_bp  (MEM_D_bp),
    .WB_D_bp   (WB_D_bp),
    .D_stall   (D_stall),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks all three bypass vectors and the stall flag in one go.
  task automatic check_bp(input string tag, input logic [1:0] ex, input logic [1:0] mem,
                          input logic [1:0] wb, input logic st);
    check({tag, ".ex"},  32'(EX_D_bp),  32'(ex));
    check({tag, ".mem"}, 32'(MEM_D_bp), 32'(mem));
    check({tag, ".wb"},  32'(WB_D_bp),  32'(wb));
    check({tag, ".stall"}, 32'(D_stall), 32'(st));
  endtask

  task automatic drive(input logic v, input logic [AW-1:0] ra, input logic ura,
                       input logic [AW-1:0] rb, input logic urb, input logic we,
                       input logic [AW-1:0] rd, input logic ld, input logic fl);
    D_valid  = v;
    D_ra     = ra;
    D_use_ra = ura;
    D_rb     = rb;
    D_use_rb = urb;
    D_we     = we;
    D_rd     = rd;
    D_ld     = ld;
    flush    = fl;
    #1;
  endtask

  task automatic writer(input logic [AW-1:0] rd, input logic ld);
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, rd, ld, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    check_bp("reset", 2'b00, 2'b00, 2'b00, 1'b0);
    check("reset.cnt", stall_cnt, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // ALU chain on r5
    writer(5'd5, 1'b0);
    tick();
    drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    check_bp("alu.t1", 2'b10, 2'b00, 2'b00, 1'b0);
    tick();
    drive(1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    check_bp("alu.t2", 2'b00, 2'b01, 2'b00, 1'b0);
    tick();
    drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    check_bp("alu.t3", 2'b00, 2'b00, 2'b10, 1'b0);
    tick();
    check_bp("alu.t4", 2'b00, 2'b00, 2'b00, 1'b0);
    tick();

    // Load-use on r7: one stall cycle, then forward from MEM
    writer(5'd7, 1'b1);
    tick();
    drive(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    check_bp("lu.t1", 2'b00, 2'b00, 2'b00, 1'b1);
    tick();
    check_bp("lu.t2", 2'b00, 2'b10, 2'b00, 1'b0);
    check("lu.cnt", stall_cnt, 32'd1);
    tick();

    // Three writers of r3; youngest wins on both operands
    writer(5'd3, 1'b0);
    tick();
    writer(5'd3, 1'b0);
    tick();
    writer(5'd3, 1'b0);
    tick();
    drive(1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    check_bp("prio", 2'b11, 2'b00, 2'b00, 1'b0);
    tick();

    // r0 never forwarded
    writer(5'd0, 1'b0);
    tick();
    drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    check_bp("r0", 2'b00, 2'b00, 2'b00, 1'b0);
    tick();

    // r4 read on ra only; rb names r4 but is unused
    writer(5'd4, 1'b0);
    tick();
    drive(1'b1, 5'd4, 1'b1, 5'd4, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    check_bp("unused_rb", 2'b10, 2'b00, 2'b00, 1'b0);
    tick();

    // Operands resolved independently from different stages
    writer(5'd10, 1'b0);
    tick();
    writer(5'd11, 1'b0);
    tick();
    drive(1'b1, 5'd10, 1'b1, 5'd11, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    check_bp("both", 2'b01, 2'b10, 2'b00, 1'b0);
    tick();

    // Flush during a would-be stall: no stall, slot (a writer of r9) is killed
    writer(5'd2, 1'b1);
    tick();
    drive(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b1);
    check_bp("flush.t1", 2'b00, 2'b00, 2'b00, 1'b0);
    check("flush.cnt1", stall_cnt, 32'd1);
    tick();
    drive(1'b1, 5'd9, 1'b1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    check_bp("flush.t2", 2'b00, 2'b01, 2'b00, 1'b0);
    check("flush.cnt2", stall_cnt, 32'd1);
    tick();

    // Two load-use stalls in a row of instructions: counter steps each time
    writer(5'd6, 1'b1);
    tick();
    drive(1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0);
    check_bp("b2b.s1", 2'b00, 2'b00, 2'b00, 1'b1);
    tick();
    check_bp("b2b.rel", 2'b00, 2'b10, 2'b00, 1'b0);
    check("b2b.cnt1", stall_cnt, 32'd2);
    tick();
    drive(1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    check_bp("b2b.s2", 2'b00, 2'b00, 2'b00, 1'b1);
    tick();
    check("b2b.cnt2", stall_cnt, 32'd3);
    check_bp("b2b.rel2", 2'b00, 2'b01, 2'b00, 1'b0);
    tick();

    // Mid-operation reset discards tracked tags and the counter
    writer(5'd12, 1'b1);
    tick();
    writer(5'd13, 1'b0);
    tick();
    drive(1'b1, 5'd12, 1'b1, 5'd13, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    check_bp("pre_rst", 2'b01, 2'b10, 2'b00, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    check_bp("mid_rst", 2'b00, 2'b00, 2'b00, 1'b0);
    check("mid_rst.cnt", stall_cnt, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_bp("post_rst", 2'b00, 2'b00, 2'b00, 1'b0);
    tick();
    check_bp("post_rst2", 2'b00, 2'b00, 2'b00, 1'b0);
    check("post_rst.cnt", stall_cnt, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
